// File: rtl/addsub_pkg.sv
// Shared definitions for the add/sub issue stage: FSM encoding, opcode
// values, saturation limits and the settle-counter width.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic        OP_ADD  = 1'b0;
    localparam logic        OP_SUB  = 1'b1;
    localparam logic [15:0] SAT_POS = 16'h7FFF;
    localparam logic [15:0] SAT_NEG = 16'h8000;

    // Settle counter holds SETTLE_CYCLES-1, so 4 bits cover 1..15.
    localparam int          CNT_W   = 4;

endpackage

// File: rtl/addsub_issue_stage_add_rca_16.sv
// 16-bit ripple-carry adder/subtractor. c_in doubles as the subtract mode
// bit: when set, b is inverted and the carry-in supplies the +1 of the
// two's complement, so c_out=1 on subtract means no borrow.
module Add_rca_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic        c_out,
    output logic [15:0] sum
);

    logic [15:0] b_eff;
    logic        carry;

    assign b_eff = b ^ {16{c_in}};

    // Ripple the carry bit by bit from LSB to MSB.
    always_comb begin
        carry = c_in;
        sum   = '0;
        for (int i = 0; i < 16; i++) begin
            sum[i] = a[i] ^ b_eff[i] ^ carry;
            carry  = (a[i] & b_eff[i]) | (carry & (a[i] ^ b_eff[i]));
        end
        c_out = carry;
    end

endmodule

// File: rtl/addsub_issue_stage.sv
// Registered issue/retire stage around Add_rca_16.
// An accepted operand pair is latched, the adder is given SETTLE_CYCLES
// cycles to ripple, then result and flags are captured and offered
// downstream. Only one operation is in flight at a time.
// Optional feature macro: ADDSUB_SAT_EN (clamp result on signed overflow).
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// The source holds valid and data stable until that edge; ready may be
// asserted independently of valid. Here in_ready depends only on state, and
// out_valid/out_* stay stable from capture until the out transfer edge.
module addsub_issue_stage
    import addsub_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_ovf,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic               op_q;

    logic               accept;
    logic               capture;

    logic [WIDTH-1:0]   raw_sum;
    logic               raw_carry;
    logic               ovf;
    logic [WIDTH-1:0]   final_result;

    // Adder only ever sees the latched operands.
    Add_rca_16 u_rca (
        .a     (a_q),
        .b     (b_q),
        .c_in  (op_q),
        .c_out (raw_carry),
        .sum   (raw_sum)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic and handshake/status outputs decoded from state.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        capture   = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign dbg_state = state_q;

    // Signed overflow from operand signs and the raw (unclamped) sum.
    always_comb begin
        if (op_q == OP_ADD)
            ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (raw_sum[WIDTH-1] != a_q[WIDTH-1]);
        else
            ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (raw_sum[WIDTH-1] != a_q[WIDTH-1]);
    end

    // Result presented downstream: clamped on overflow when saturation is built in.
    always_comb begin
`ifdef ADDSUB_SAT_EN
        if (ovf) final_result = a_q[WIDTH-1] ? SAT_NEG : SAT_POS;
        else     final_result = raw_sum;
`else
        final_result = raw_sum;
`endif
    end

    // Operand latch and settle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= OP_ADD;
            cnt_q <= '0;
        end else if (accept) begin
            a_q   <= in_a;
            b_q   <= in_b;
            op_q  <= in_op;
            cnt_q <= CNT_W'(SETTLE_CYCLES - 1);
        end else if (state_q == SETTLE && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Output registers: loaded once per op at capture, held until the next capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_result <= '0;
            out_carry  <= 1'b0;
            out_zero   <= 1'b0;
            out_neg    <= 1'b0;
            out_ovf    <= 1'b0;
        end else if (capture) begin
            out_result <= final_result;
            out_carry  <= raw_carry;
            out_zero   <= (final_result == '0);
            out_neg    <= final_result[WIDTH-1];
            out_ovf    <= ovf;
        end
    end

endmodule
